alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the 32-bit ALU.
- Captures each ALU result word (Y) with its status flags (Cout, Negative, Zero, Overflow) and the opcode (sel) that produced it.
- Buffers these entries in a small FIFO behind a valid/ready handshake, so the consumer (writeback/display logic) can stall without losing results.
- Also keeps sticky status flags and a count of completed operations for the bench and the status display.

Parameters:
DATA_W, 32, width of ALU result word
DEPTH, 4, number of FIFO entries; power of two, at least 2
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ALU result present this cycle
in_ready  output  1  FIFO can accept an entry
in_y  input  DATA_W  ALU result Y
in_sel  input  4  ALU opcode that produced in_y
in_cout  input  1  ALU carry out
in_neg  input  1  ALU Negative flag
in_zero  input  1  ALU Zero flag
in_ovf  input  1  ALU Overflow flag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_y  output  DATA_W  head result word
out_sel  output  4  head opcode
out_flags  output  4  head flags {N,Z,C,V}
sticky_flags  output  4  OR of {N,Z,C,V} over all accepted entries since reset or clear
sticky_clr  input  1  synchronous clear of sticky_flags
op_count  output  CNT_W  number of accepted entries, saturating
level  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst_n low asynchronously clears the following, regardless of clk.
  - Read/write pointers, level, sticky_flags and op_count go to 0.
  - out_valid=0; in_ready=1 once rst_n is released.
  - out_y, out_sel and out_flags = 0.
- Reset mid-operation discards all stored entries; nothing is emitted after reset deasserts until a new push.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (level != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (level != 0). out_* present the entry at the read pointer straight from storage (first-word fall-through).
- Latency: an entry pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1).
- Occupancy states (derived from level):
  - EMPTY: push only -> PARTIAL.
  - PARTIAL: push only -> PARTIAL or FULL; pop only -> PARTIAL or EMPTY; push and pop together -> level unchanged.
  - FULL: in_ready=0, so no push; pop -> PARTIAL.
- Simultaneous push and pop:
  - Allowed in PARTIAL, including level=1, where head is replaced by the next entry in the following cycle.
  - In EMPTY no pop is possible, so only the push takes effect.
  - In FULL only the pop takes effect; the input stalls one cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately so full and empty are never ambiguous.
- Stored flags are packed as {in_neg,in_zero,in_cout,in_ovf}. Values are taken exactly as given; no recomputation.
- sticky_flags update on push: sticky <= sticky | pushed_flags.
  - sticky_clr alone: sticky <= 0.
  - sticky_clr together with push: sticky <= pushed_flags (clear wins over old contents, not over the new entry).
- op_count increments by 1 on each push and saturates at 2^CNT_W-1 without wrapping. Pops do not affect it.
- in_* are sampled only on push. out_* hold steady while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_RESULT_BYPASS_EN.
- Defined: when level==0 and in_valid=1, out_valid=1 combinationally and out_y/out_sel/out_flags = in_* the same cycle.
  - If out_ready=1 as well, the entry passes through without being written: level stays 0.
  - sticky_flags and op_count still update as for a push.
  - If out_ready=0, the entry is written normally.
- Undefined: fixed 1-cycle latency as above; no combinational path from in_* to out_*.

Test Plan:
1. Reset then idle: rst_n low 3 cycles then high -> out_valid=0, in_ready=1, level=0, op_count=0, sticky_flags=4'b0000.
2. Single push: in_y=32'hDEADBEEF, in_sel=4'b0100, flags N=1,Z=0,C=0,V=0, out_ready=0 -> next cycle out_valid=1, out_y=32'hDEADBEEF, out_flags=4'b1000, level=1, op_count=1.
3. Fill, then stall: push 5 entries (y=1..5) with out_ready=0, DEPTH=4 -> in_ready=0 after 4th push, level=4; then out_ready=1 -> outputs y=1,2,3,4 in order, 5th is accepted once space frees.
4. Concurrent push/pop at level=2 for 10 cycles, pointers wrapping -> level stays 2, outputs in exact push order with no loss or duplicate.
5. Sticky: push Z=1 entry, then C=1 entry -> sticky=4'b0110; assert sticky_clr with a V=1 push the same cycle -> sticky=4'b0001.
6. Reset mid-burst at level=3 -> out_valid=0 immediately (asynchronously), level=0; after release the first output is the first post-reset push. With CNT_W=2, 5 pushes -> op_count=3.

Source files
------------

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   Result buffer that sits after the 32-bit ALU. Each accepted entry holds the
//   result word, the opcode that produced it and the flags {N,Z,C,V}. A
//   first-word-fall-through FIFO lets the consumer stall without losing results.
//   Sticky flags and a saturating count of accepted operations are kept for the
//   status display.
//
//   Handshake: a transfer happens on a rising clk edge when valid && ready are
//   both high on that side. in_ready depends only on registered occupancy.
//   When out_valid is high and out_ready is low, out_* hold steady.
//
//   Optional build macro: ALU_RESULT_BYPASS_EN
//     defined   - when the FIFO is empty, in_* are forwarded combinationally to
//                 out_*. If out_ready is also high, the entry is consumed
//                 without being stored.
//     undefined - fixed one-cycle latency from in_* to out_*, with no
//                 combinational path between them.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   in_y, in_sel      ALU result word and opcode
//   in_cout, in_neg, in_zero, in_ovf   ALU flags
//   out_valid/out_ready downstream handshake
//   out_y, out_sel, out_flags  head entry, flags packed as {N,Z,C,V}
//   sticky_flags      OR of the flags of all accepted entries
//   sticky_clr        synchronous clear of sticky_flags
//   op_count          saturating count of accepted entries
//   level             current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_y,
  input  logic [3:0]                in_sel,
  input  logic                      in_cout,
  input  logic                      in_neg,
  input  logic                      in_zero,
  input  logic                      in_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_y,
  output logic [3:0]                out_sel,
  output logic [3:0]                out_flags,
  output logic [3:0]                sticky_flags,
  input  logic                      sticky_clr,
  output logic [CNT_W-1:0]          op_count,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem_y     [DEPTH];
  logic [3:0]        r_mem_sel   [DEPTH];
  logic [3:0]        r_mem_flags [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [3:0]        r_sticky;
  logic [CNT_W-1:0]  r_op_count;

  logic [3:0]        w_in_flags;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_bypass;
  logic              w_write;
  logic              w_pop_mem;

  assign w_in_flags = {in_neg, in_zero, in_cout, in_ovf};
  // level is kept separately from the pointers, so equal pointers never
  // leave full and empty ambiguous.
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(DEPTH));
  assign in_ready   = !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_pop_mem  = !w_empty && out_ready;
  assign w_write    = w_push && !w_bypass;

`ifdef ALU_RESULT_BYPASS_EN
  // An empty FIFO presents the incoming word directly. A word that the
  // consumer takes in that same cycle never occupies storage.
  assign w_bypass  = w_empty && in_valid && out_ready;
  assign out_valid = !w_empty || in_valid;
  always_comb begin
    out_y     = r_mem_y[r_rd_ptr];
    out_sel   = r_mem_sel[r_rd_ptr];
    out_flags = r_mem_flags[r_rd_ptr];
    if (w_empty && in_valid) begin
      out_y     = in_y;
      out_sel   = in_sel;
      out_flags = w_in_flags;
    end
  end
`else
  assign w_bypass  = 1'b0;
  assign out_valid = !w_empty;
  assign out_y     = r_mem_y[r_rd_ptr];
  assign out_sel   = r_mem_sel[r_rd_ptr];
  assign out_flags = r_mem_flags[r_rd_ptr];
`endif

  assign sticky_flags = r_sticky;
  assign op_count     = r_op_count;
  assign level        = r_level;

  // Storage is reset so that out_* read as zero straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_y[i]     <= '0;
        r_mem_sel[i]   <= '0;
        r_mem_flags[i] <= '0;
      end
    end else if (w_write) begin
      r_mem_y[r_wr_ptr]     <= in_y;
      r_mem_sel[r_wr_ptr]   <= in_sel;
      r_mem_flags[r_wr_ptr] <= w_in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_mem) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_write, w_pop_mem})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A clear issued in the same cycle as a push drops the old contents but
  // keeps the flags of the entry being pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (w_push) begin
      r_sticky <= sticky_clr ? w_in_flags : (r_sticky | w_in_flags);
    end else if (sticky_clr) begin
      r_sticky <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_push && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//   Bench for alu_result_fifo. The reference model holds the expected entries
//   in a queue, with the sticky flags and the saturating count beside it. A
//   compare process checks every DUT output on each falling edge. Directed
//   phases add literal expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int EW     = DATA_W + 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_y = '0;
  logic [3:0]        in_sel = '0;
  logic              in_cout = 1'b0;
  logic              in_neg = 1'b0;
  logic              in_zero = 1'b0;
  logic              in_ovf = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_y;
  logic [3:0]        out_sel;
  logic [3:0]        out_flags;
  logic [3:0]        sticky_flags;
  logic              sticky_clr = 1'b0;
  logic [CNT_W-1:0]  op_count;
  logic [LW-1:0]     level;

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_sel(in_sel),
    .in_cout(in_cout), .in_neg(in_neg), .in_zero(in_zero), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_sel(out_sel), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .op_count(op_count), .level(level)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic [3:0]    m_sticky = '0;
  int            m_count  = 0;
  bit            m_push, m_pop, m_byp;
  logic [3:0]    m_fl;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_sticky = '0;
      m_count  = 0;
    end else begin
      m_fl   = {in_neg, in_zero, in_cout, in_ovf};
      m_push = in_valid && (exp_q.size() < DEPTH);
      m_pop  = (exp_q.size() > 0) && out_ready;
      m_byp  = 1'b0;
`ifdef ALU_RESULT_BYPASS_EN
      m_byp  = (exp_q.size() == 0) && in_valid && out_ready;
`endif
      if (m_pop) void'(exp_q.pop_front());
      if (m_push && !m_byp) exp_q.push_back({in_y, in_sel, m_fl});
      if (m_push) begin
        m_sticky = sticky_clr ? m_fl : (m_sticky | m_fl);
        if (m_count < CMAX) m_count++;
      end else if (sticky_clr) begin
        m_sticky = '0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [EW-1:0] c_head;
  bit            c_valid;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      c_valid = exp_q.size() > 0;
      c_head  = (exp_q.size() > 0) ? exp_q[0] : '0;
`ifdef ALU_RESULT_BYPASS_EN
      if (exp_q.size() == 0 && in_valid) begin
        c_valid = 1'b1;
        c_head  = {in_y, in_sel, in_neg, in_zero, in_cout, in_ovf};
      end
`endif
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(c_valid));
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("op_count", 64'(op_count), 64'(m_count));
      chk("sticky", 64'(sticky_flags), 64'(m_sticky));
      if (c_valid) begin
        chk("out_y", 64'(out_y), 64'(c_head[EW-1:8]));
        chk("out_sel", 64'(out_sel), 64'(c_head[7:4]));
        chk("out_flags", 64'(out_flags), 64'(c_head[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs and returns just after the next rising edge.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] y, input logic [3:0] sel,
                     input logic [3:0] fl, input logic ordy, input logic clr);
    in_valid   = v;
    in_y       = y;
    in_sel     = sel;
    in_neg     = fl[3];
    in_zero    = fl[2];
    in_cout    = fl[1];
    in_ovf     = fl[0];
    out_ready  = ordy;
    sticky_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (6) cyc(1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // 1: reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);

    // 2: single push, visible one cycle later
    cyc(1'b1, 32'hDEADBEEF, 4'b0100, 4'b1000, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("p1_out_valid", 64'(out_valid), 64'd1);
    chk("p1_out_y", 64'(out_y), 64'hDEADBEEF);
    chk("p1_out_sel", 64'(out_sel), 64'd4);
    chk("p1_out_flags", 64'(out_flags), 64'b1000);
    chk("p1_level", 64'(level), 64'd1);
    chk("p1_op_count", 64'(op_count), 64'd1);
    drain();

    // 3: fill past capacity, then release the consumer
    for (int i = 1; i <= 5; i++) cyc(1'b1, DATA_W'(i), 4'd1, 4'd0, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_level", 64'(level), 64'd4);
    chk("full_head", 64'(out_y), 64'd1);
    cyc(1'b1, 32'd5, 4'd1, 4'd0, 1'b1, 1'b0);
    chk("unstall_level", 64'(level), 64'd3);
    chk("unstall_head", 64'(out_y), 64'd2);
    cyc(1'b1, 32'd5, 4'd1, 4'd0, 1'b1, 1'b0);
    chk("sat_op_count", 64'(op_count), 64'(CMAX));
    drain();

    // 4: concurrent push/pop at level 2, pointers wrap
    cyc(1'b1, 32'h100, 4'd2, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h101, 4'd2, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, DATA_W'(32'h102 + i), 4'd3, 4'(i), 1'b1, 1'b0);
      chk("pp_level", 64'(level), 64'd2);
      chk("pp_head", 64'(out_y), 64'(32'h101 + i));
    end
    drain();

    // 5: sticky flags
    cyc(1'b0, '0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("sticky_clr_alone", 64'(sticky_flags), 64'd0);
    cyc(1'b1, 32'h0, 4'd5, 4'b0100, 1'b1, 1'b0);
    cyc(1'b1, 32'h1, 4'd5, 4'b0010, 1'b1, 1'b0);
    chk("sticky_or", 64'(sticky_flags), 64'b0110);
    cyc(1'b1, 32'h2, 4'd5, 4'b0001, 1'b1, 1'b1);
    chk("sticky_clr_push", 64'(sticky_flags), 64'b0001);
    drain();

    // 6: reset in the middle of a burst
    for (int i = 0; i < 3; i++) cyc(1'b1, DATA_W'(32'h200 + i), 4'd6, 4'd0, 1'b0, 1'b0);
    chk("mid_level", 64'(level), 64'd3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_level", 64'(level), 64'd0);
    chk("async_op_count", 64'(op_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 32'hA5A50001, 4'd7, 4'b0000, 1'b0, 1'b0);
    chk("post_rst_head", 64'(out_y), 64'hA5A50001);
    chk("post_rst_level", 64'(level), 64'd1);
    for (int i = 2; i <= 5; i++) cyc(1'b1, DATA_W'(32'hA5A50000 + i), 4'd7, 4'd0, 1'b1, 1'b0);
    chk("post_rst_op_count", 64'(op_count), 64'd3);
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
